spi_adc_sampler: RTL and testbench

- Parametrised SPI master that reads serial ADCs; successor to the fixed 16-bit PmodALS light-sensor controller.
- Generates CS and SCL and shifts in a FRAME_W-bit MSB-first frame from sdo.
- Extracts a DATA_W-bit field and presents it with a one-cycle valid strobe.
- Supports single-shot and continuous modes with a programmable inter-frame gap; sits between the Pmod header pins and the display/processing logic.

---
 rtl/spi_adc_sampler.sv | 187 ++++++++++++++++++
 tb/tb_spi_adc_sampler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_sampler.sv
// SPI master for serial ADCs: frames CS/SCL, shifts in FRAME_W bits MSB-first, reports a DATA_W field.
// Define SPI_ADC_AVG_EN to average 2^AVG_LOG2 consecutive samples before reporting.
module spi_adc_sampler #(
    parameter int FRAME_W    = 16,
    parameter int DATA_W     = 8,
    parameter int DATA_LSB   = 4,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int GAP_CYCLES = 16
`ifdef SPI_ADC_AVG_EN
    ,
    parameter int AVG_LOG2   = 2
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               start,
    input  logic               sdo,
    output logic               scl,
    output logic               cs,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic [FRAME_W-1:0] raw,
    output logic               busy
);

    localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CNT_MAX = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               scl_q, scl_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] raw_q, raw_d;
    logic [DATA_W-1:0]  sample_q, sample_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  field;

    assign field = shift_q[DATA_LSB +: DATA_W];

`ifdef SPI_ADC_AVG_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [AVG_LOG2-1:0] avg_cnt_q, avg_cnt_d;
    logic [ACC_W-1:0]    acc_sum;

    assign acc_sum = acc_q + ACC_W'(field);
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path leaves one unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_cnt_d = bit_cnt_q;
        scl_d     = scl_q;
        shift_d   = shift_q;
        raw_d     = raw_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
`ifdef SPI_ADC_AVG_EN
        acc_d     = acc_q;
        avg_cnt_d = avg_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (en && (mode || start)) begin
                    state_d   = S_SETUP;
                    bit_cnt_d = '0;
`ifdef SPI_ADC_AVG_EN
                    acc_d     = '0;
                    avg_cnt_d = '0;
`endif
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    scl_d   = 1'b0;
                end
            end
            S_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!scl_q) begin
                        // Capture on the rising SCL edge; the ADC changes sdo on the falling one.
                        scl_d     = 1'b1;
                        shift_d   = {shift_q[FRAME_W-2:0], sdo};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end else if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        scl_d = 1'b0;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    raw_d   = shift_q;
`ifdef SPI_ADC_AVG_EN
                    if (avg_cnt_q == '1) begin
                        sample_d  = acc_sum[AVG_LOG2 +: DATA_W];
                        valid_d   = 1'b1;
                        acc_d     = '0;
                        avg_cnt_d = '0;
                    end else begin
                        acc_d     = acc_sum;
                        avg_cnt_d = avg_cnt_q + AVG_LOG2'(1);
                    end
`else
                    sample_d = field;
                    valid_d  = 1'b1;
`endif
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = (mode && en) ? S_SETUP : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            scl_q     <= 1'b1;
            shift_q   <= '0;
            raw_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
`ifdef SPI_ADC_AVG_EN
            acc_q     <= '0;
            avg_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            scl_q     <= scl_d;
            shift_q   <= shift_d;
            raw_q     <= raw_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
`ifdef SPI_ADC_AVG_EN
            acc_q     <= acc_d;
            avg_cnt_q <= avg_cnt_d;
`endif
        end
    end

    assign cs           = !(state_q inside {S_SETUP, S_SHIFT, S_HOLD});
    assign busy         = (state_q != S_IDLE);
    assign scl          = scl_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign raw          = raw_q;

endmodule

// File: tb/tb_spi_adc_sampler.sv
// Scoreboard bench for spi_adc_sampler at default parameters; an ADC model drives sdo from a frame queue.
module tb_spi_adc_sampler;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 8;
    localparam int LAT     = 2 + 2 * 4 * 16 + 4;  // 134
    localparam int GAP     = 16;
    localparam int PERIOD  = LAT + GAP;           // 150

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               mode = 1'b0;
    logic               start = 1'b0;
    logic               sdo = 1'b0;
    logic               scl, cs, sample_valid, busy;
    logic [DATA_W-1:0]  sample;
    logic [FRAME_W-1:0] raw;

    typedef struct {
        logic [DATA_W-1:0]  smp;
        logic [FRAME_W-1:0] frm;
        int                 cyc;
    } exp_t;

    exp_t               exp_q[$];
    logic [FRAME_W-1:0] adc_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int scl_rises = 0;
    int rises_at_fall = 0;
    int cs_falls = 0;
    int last_rise = 0;
    bit have_rise = 1'b0;

    spi_adc_sampler dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .start        (start),
        .sdo          (sdo),
        .scl          (scl),
        .cs           (cs),
        .sample       (sample),
        .sample_valid (sample_valid),
        .raw          (raw),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    function automatic logic [FRAME_W-1:0] frame_of(input logic [DATA_W-1:0] v);
        return {4'h0, v, 4'h0};
    endfunction

    // ADC model: new bit on every SCL fall while selected, MSB first.
    initial begin
        logic [FRAME_W-1:0] cur;
        forever begin
            @(negedge cs);
            cur = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
            for (int i = FRAME_W - 1; i >= 0; i--) begin
                @(negedge scl or posedge cs);
                if (cs) break;
                sdo = cur[i];
            end
        end
    end

    always @(posedge scl) scl_rises = scl_rises + 1;
    always @(posedge cs) begin
        last_rise = cyc;
        have_rise = 1'b1;
    end
    always @(negedge cs) begin
        cs_falls      = cs_falls + 1;
        rises_at_fall = scl_rises;
        if (have_rise) check("cs_gap_min", 64'((cyc - last_rise) >= GAP), 64'd1);
    end

    // Monitor: every valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sample", 64'(sample), 64'(e.smp));
                check("raw", 64'(raw), 64'(e.frm));
                check("valid_cycle", 64'(cyc), 64'(e.cyc));
                check("scl_rises", 64'(scl_rises - rises_at_fall), 64'(FRAME_W));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int f;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("reset_cs", 64'(cs), 64'd1);
        check("reset_scl", 64'(scl), 64'd1);
        check("reset_sample", 64'(sample), 64'd0);
        check("reset_raw", 64'(raw), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

`ifdef SPI_ADC_AVG_EN
        // Four continuous frames 10,20,30,41 -> one report of 101>>2 = 25.
        mode = 1'b1;
        adc_q.push_back(frame_of(8'd10));
        adc_q.push_back(frame_of(8'd20));
        adc_q.push_back(frame_of(8'd30));
        adc_q.push_back(frame_of(8'd41));
        c = cyc;
        exp_q.push_back('{8'd25, frame_of(8'd41), c + 1 + 3 * PERIOD + LAT});
        en = 1'b1;
        wait_until(c + 1 + 3 * PERIOD + 10);
        en = 1'b0;
        wait_until(c + 1 + 4 * PERIOD);
        check("avg_busy_done", 64'(busy), 64'd0);
        check("avg_raw_last", 64'(raw), 64'(frame_of(8'd41)));
        mode = 1'b0;
`else
        // start together with en=0 is ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("start_no_en_busy", 64'(busy), 64'd0);

        // Single-shot frame; a second start mid-frame must be ignored.
        en = 1'b1;
        adc_q.push_back(16'h0AB0);
        c = cyc;
        exp_q.push_back('{8'hAB, 16'h0AB0, c + 1 + LAT});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ss_cs_low", 64'(cs), 64'd0);
        wait_until(c + 40);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(c + LAT + GAP);
        check("ss_busy_in_gap", 64'(busy), 64'd1);
        @(negedge clk);
        check("ss_busy_done", 64'(busy), 64'd0);
        repeat (20) @(negedge clk);
        check("ss_no_restart", 64'(busy), 64'd0);

        // Continuous: two frames, en dropped inside the second.
        adc_q.push_back(16'h0120);
        adc_q.push_back(16'h0FF0);
        c = cyc;
        exp_q.push_back('{8'h12, 16'h0120, c + 1 + LAT});
        exp_q.push_back('{8'hFF, 16'h0FF0, c + 1 + PERIOD + LAT});
        mode = 1'b1;
        wait_until(c + 1 + PERIOD + 10);
        en = 1'b0;
        wait_until(c + 1 + 2 * PERIOD);
        check("cont_busy_done", 64'(busy), 64'd0);
        repeat (10) @(negedge clk);

        // en dropped mid-frame: frame completes, then no further CS fall.
        adc_q.push_back(16'h0550);
        c = cyc;
        f = cs_falls;
        exp_q.push_back('{8'h55, 16'h0550, c + 1 + LAT});
        en = 1'b1;
        wait_until(c + 50);
        en = 1'b0;
        wait_until(c + 1 + PERIOD + 200);
        check("endrop_one_frame", 64'(cs_falls - f), 64'd1);
        check("endrop_idle", 64'(busy), 64'd0);
        check("endrop_cs_high", 64'(cs), 64'd1);
        mode = 1'b0;

        // Reset during SHIFT with scl low (around bit 7): abort, then a clean frame.
        en = 1'b1;
        adc_q.push_back(16'h0FF0);
        c = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(c + 59);
        check("abort_pre_scl", 64'(scl), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs", 64'(cs), 64'd1);
        check("abort_scl", 64'(scl), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sample", 64'(sample), 64'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        adc_q.push_back(16'h0C30);
        c = cyc;
        exp_q.push_back('{8'hC3, 16'h0C30, c + 1 + LAT});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(c + 1 + PERIOD);
        check("post_abort_idle", 64'(busy), 64'd0);
        en = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("all_valids_seen", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
